// File: rtl/header_dispatcher_pkg.sv
//==============================================================================
// Module : header_dispatcher_pkg
// Brief  : NoC packet definitions shared by the dispatcher and processing_element.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package header_dispatcher_pkg;

   localparam int DATA_W    = 64;
   localparam int DEST_BITS = 5;
   localparam int VC_BITS   = 2;
   localparam int FLIT_W    = 2 + DEST_BITS + VC_BITS + DATA_W;

   localparam int DATA_LSB  = 0;
   localparam int VC_LSB    = DATA_LSB + DATA_W;
   localparam int DEST_LSB  = VC_LSB + VC_BITS;
   localparam int TAIL_BIT  = DEST_LSB + DEST_BITS;
   localparam int VALID_BIT = TAIL_BIT + 1;

   localparam int HDR_FLITS = 10;
   localparam int RES_FLITS = 3;

   localparam logic [DATA_W-1:0] FOUND_BITCOIN_MSG = 64'h1;
   localparam logic [2:0]        CREDIT_VC0        = 3'b100;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_DONE = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_MAGIC = 2'd0,
      RX_NONCE = 2'd1,
      RX_CLK   = 2'd2,
      RX_DROP  = 2'd3
   } rx_state_t;

   function automatic flit_t make_flit(input logic                 tail,
                                       input logic [DEST_BITS-1:0] dest,
                                       input logic [VC_BITS-1:0]   vc,
                                       input logic [DATA_W-1:0]    data);
      return {1'b1, tail, dest, vc, data};
   endfunction

endpackage

`default_nettype wire

// File: rtl/header_dispatcher_if.sv
//==============================================================================
// Module : header_dispatcher_if
// Brief  : Injection/ejection port pair between node 0 and the NoC router.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface header_dispatcher_if;
   import header_dispatcher_pkg::*;

   flit_t      put_flit;
   logic       en_put_flit;
   logic [2:0] credit_out;
   flit_t      get_flit;
   logic       send_credit;
   logic [2:0] credit_in;

   modport master (
      output put_flit, en_put_flit, send_credit, credit_in,
      input  credit_out, get_flit
   );

   modport slave (
      input  put_flit, en_put_flit, send_credit, credit_in,
      output credit_out, get_flit
   );
endinterface

`default_nettype wire

// File: rtl/header_dispatcher_result_collector.sv
//==============================================================================
// Module : result_collector
// Brief  : Parses 3-flit result packets, returns a credit per ejected flit and
//          latches the first valid result.
// Config : RESULT_MAGIC_CHECK_EN enables magic-word check and bad_pkts counter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module result_collector
   import header_dispatcher_pkg::*;
(
   input  logic        sys_clk,
   input  logic        reset,
   input  flit_t       get_flit,
   output logic        send_credit,
   output logic [2:0]  credit_in,
   output logic        found,
   output logic [31:0] win_nonce,
   output logic [63:0] win_clks
`ifdef RESULT_MAGIC_CHECK_EN
   ,
   output logic [15:0] bad_pkts
`endif
);

   rx_state_t         r_rx_state;
   rx_state_t         w_rx_next;
   logic [31:0]       r_nonce_tmp;
   logic              w_valid;
   logic              w_tail;
   logic [DATA_W-1:0] w_data;
   logic              w_store_nonce;
   logic              w_capture;
   logic              w_unused_fields;
`ifdef RESULT_MAGIC_CHECK_EN
   logic              w_bad_magic;
`endif

   assign w_valid = get_flit[VALID_BIT];
   assign w_tail  = get_flit[TAIL_BIT];
   assign w_data  = get_flit[DATA_LSB +: DATA_W];
   // Routing fields are meaningless once the flit has been ejected here.
   assign w_unused_fields = &{1'b0, get_flit[VC_LSB +: VC_BITS + DEST_BITS]};

   always_ff @(posedge sys_clk) begin
      if (!reset) r_rx_state <= RX_MAGIC;
      else        r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next     = r_rx_state;
      w_store_nonce = 1'b0;
      w_capture     = 1'b0;
`ifdef RESULT_MAGIC_CHECK_EN
      w_bad_magic   = 1'b0;
`endif
      if (w_valid) begin
         case (r_rx_state)
            RX_MAGIC: begin
               if (w_tail) begin
                  w_rx_next = RX_MAGIC;
               end else begin
`ifdef RESULT_MAGIC_CHECK_EN
                  if (w_data != FOUND_BITCOIN_MSG) begin
                     w_bad_magic = 1'b1;
                     w_rx_next   = RX_DROP;
                  end else begin
                     w_rx_next   = RX_NONCE;
                  end
`else
                  w_rx_next = RX_NONCE;
`endif
               end
            end
            RX_NONCE: begin
               if (w_tail) begin
                  w_rx_next = RX_MAGIC;
               end else begin
                  w_store_nonce = 1'b1;
                  w_rx_next     = RX_CLK;
               end
            end
            RX_CLK: begin
               // An over-long packet is drained to its tail without capture.
               if (w_tail) begin
                  w_capture = !found;
                  w_rx_next = RX_MAGIC;
               end else begin
                  w_rx_next = RX_DROP;
               end
            end
            RX_DROP: begin
               if (w_tail) w_rx_next = RX_MAGIC;
            end
            default: w_rx_next = RX_MAGIC;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         send_credit <= 1'b0;
         credit_in   <= 3'b000;
         r_nonce_tmp <= '0;
         found       <= 1'b0;
         win_nonce   <= '0;
         win_clks    <= '0;
`ifdef RESULT_MAGIC_CHECK_EN
         bad_pkts    <= '0;
`endif
      end else begin
         send_credit <= w_valid;
         credit_in   <= w_valid ? CREDIT_VC0 : 3'b000;
         if (w_store_nonce) r_nonce_tmp <= w_data[31:0];
         if (w_capture) begin
            found     <= 1'b1;
            win_nonce <= r_nonce_tmp;
            win_clks  <= w_data;
         end
`ifdef RESULT_MAGIC_CHECK_EN
         if (w_bad_magic && (bad_pkts != 16'hFFFF)) bad_pkts <= bad_pkts + 16'd1;
`endif
      end
   end

endmodule

`default_nettype wire

// File: rtl/header_dispatcher.sv
//==============================================================================
// Module : header_dispatcher
// Brief  : Node-0 endpoint: streams the block header round-robin to the PEs and
//          collects the first mining result.
// Config : RESULT_MAGIC_CHECK_EN adds result magic check and bad_pkts output.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module header_dispatcher #(
   parameter int NUM_PE    = 5,
   parameter int CREDITS   = 4,
   parameter int HDR_FLITS = 10
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [HDR_FLITS*64-1:0] header_in,
   header_dispatcher_if.master     noc,
   output logic                    found,
   output logic [31:0]             win_nonce,
   output logic [63:0]             win_clks,
   output logic [31:0]             pkts_sent,
   output logic                    busy
`ifdef RESULT_MAGIC_CHECK_EN
   ,
   output logic [15:0]             bad_pkts
`endif
);
   import header_dispatcher_pkg::*;

   localparam int c_hdr_w  = HDR_FLITS * DATA_W;
   localparam int c_idx_w  = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
   localparam int c_cred_w = $clog2(CREDITS + 1);

   localparam logic [c_idx_w-1:0]   c_last_idx  = c_idx_w'(HDR_FLITS - 1);
   localparam logic [c_cred_w-1:0]  c_cred_max  = c_cred_w'(CREDITS);
   localparam logic [DEST_BITS-1:0] c_last_dest = DEST_BITS'(NUM_PE);
   localparam logic [DEST_BITS-1:0] c_first_dest = DEST_BITS'(1);

   tx_state_t            r_tx_state;
   tx_state_t            w_tx_next;
   logic [c_hdr_w-1:0]   r_hdr;
   logic [c_idx_w-1:0]   r_flit_idx;
   logic [DEST_BITS-1:0] r_dest;
   logic [c_cred_w-1:0]  r_credits;
   logic [31:0]          r_pkts;
   flit_t                r_put_flit;
   logic                 r_en_put;
   logic                 w_inject;
   logic                 w_last;
   logic                 w_credit_ret;
   logic [DATA_W-1:0]    w_hdr_word;

   assign w_last       = (r_flit_idx == c_last_idx);
   assign w_hdr_word   = r_hdr[DATA_W*r_flit_idx +: DATA_W];
   assign w_credit_ret = noc.credit_out[2] && (noc.credit_out[1:0] == 2'b00);

   always_ff @(posedge sys_clk) begin
      if (!reset) r_tx_state <= TX_IDLE;
      else        r_tx_state <= w_tx_next;
   end

   // found is only honoured at a packet boundary so PEs never see a truncated header.
   always_comb begin
      w_tx_next = r_tx_state;
      w_inject  = 1'b0;
      case (r_tx_state)
         TX_IDLE: if (start) w_tx_next = TX_SEND;
         TX_SEND: begin
            if (r_credits != '0) begin
               w_inject = 1'b1;
               if (w_last && found) w_tx_next = TX_DONE;
            end
         end
         TX_DONE: w_tx_next = TX_DONE;
         default: w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         r_hdr      <= '0;
         r_flit_idx <= '0;
         r_dest     <= c_first_dest;
         r_credits  <= c_cred_max;
         r_pkts     <= '0;
         r_put_flit <= '0;
         r_en_put   <= 1'b0;
      end else begin
         if ((r_tx_state == TX_IDLE) && start) r_hdr <= header_in;

         r_en_put   <= w_inject;
         r_put_flit <= w_inject ? make_flit(w_last, r_dest, 2'b00, w_hdr_word) : '0;

         if (w_inject) begin
            if (w_last) begin
               r_flit_idx <= '0;
               r_pkts     <= r_pkts + 32'd1;
               r_dest     <= (r_dest == c_last_dest) ? c_first_dest : r_dest + 1'b1;
            end else begin
               r_flit_idx <= r_flit_idx + 1'b1;
            end
         end

         case ({w_inject, w_credit_ret})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   if (r_credits != c_cred_max) r_credits <= r_credits + 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   assign noc.put_flit    = r_put_flit;
   assign noc.en_put_flit = r_en_put;
   assign pkts_sent       = r_pkts;
   assign busy            = (r_tx_state == TX_SEND);

   result_collector u_result_collector (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .get_flit    (noc.get_flit),
      .send_credit (noc.send_credit),
      .credit_in   (noc.credit_in),
      .found       (found),
      .win_nonce   (win_nonce),
      .win_clks    (win_clks)
`ifdef RESULT_MAGIC_CHECK_EN
      ,
      .bad_pkts    (bad_pkts)
`endif
   );

endmodule

`default_nettype wire
